// File: rtl/alu_arbiter.sv
// Round-robin controller sharing one external combinational ALU between two
// requesters; one operation in flight, result returned over a valid/ready channel.
module alu_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_f,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_f,
   output logic             rsp_id,
   output logic             rsp_dz
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             last_r;
   logic             id_r;
   logic             dz_r;
   logic [WIDTH-1:0] alu_a_r;
   logic [WIDTH-1:0] alu_b_r;
   logic [1:0]       alu_op_r;
   logic             rsp_valid_r;
   logic [WIDTH-1:0] rsp_f_r;
   logic             rsp_id_r;
   logic             rsp_dz_r;

   logic             gnt0_s;
   logic             gnt1_s;
   logic             acc_s;
   logic [WIDTH-1:0] sel_a_s;
   logic [WIDTH-1:0] sel_b_s;
   logic [1:0]       sel_op_s;
   logic             sel_dz_s;

   // Round-robin grant; ready is held low while rst is high so no handshake is seen.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if ((state_r == IDLE) && !rst) begin
         if (req0_valid && req1_valid) begin
            gnt0_s = last_r;
            gnt1_s = !last_r;
         end else begin
            gnt0_s = req0_valid;
            gnt1_s = req1_valid;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Operand select for the granted requester and divide-by-zero detection.
   always_comb begin
      acc_s    = gnt0_s || gnt1_s;
      sel_a_s  = gnt1_s ? req1_a  : req0_a;
      sel_b_s  = gnt1_s ? req1_b  : req0_b;
      sel_op_s = gnt1_s ? req1_op : req0_op;
      sel_dz_s = (sel_op_s == 2'b11) && (sel_b_s == {WIDTH{1'b0}});
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    state_nxt_s = acc_s ? EXEC : IDLE;
         EXEC:    state_nxt_s = RESP;
         RESP:    state_nxt_s = rsp_ready ? IDLE : RESP;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, operand and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         last_r      <= 1'b1;
         id_r        <= 1'b0;
         dz_r        <= 1'b0;
         alu_a_r     <= {WIDTH{1'b0}};
         alu_b_r     <= {WIDTH{1'b0}};
         alu_op_r    <= 2'b00;
         rsp_valid_r <= 1'b0;
         rsp_f_r     <= {WIDTH{1'b0}};
         rsp_id_r    <= 1'b0;
         rsp_dz_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            IDLE: begin
               if (acc_s) begin
                  alu_a_r  <= sel_a_s;
                  alu_b_r  <= sel_b_s;
                  alu_op_r <= sel_op_s;
                  id_r     <= gnt1_s;
                  dz_r     <= sel_dz_s;
                  last_r   <= gnt1_s;
               end
            end
            EXEC: begin
               // The ALU's own divide-by-zero output is replaced by all-ones.
               rsp_f_r     <= dz_r ? {WIDTH{1'b1}} : alu_f;
               rsp_id_r    <= id_r;
               rsp_dz_r    <= dz_r;
               rsp_valid_r <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign req0_ready = gnt0_s;
   assign req1_ready = gnt1_s;
   assign alu_a      = alu_a_r;
   assign alu_b      = alu_b_r;
   assign alu_op     = alu_op_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_f      = rsp_f_r;
   assign rsp_id     = rsp_id_r;
   assign rsp_dz     = rsp_dz_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU attached.
module tb_alu_arbiter;

   logic       clk;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0] req0_op, req1_op;
   logic [7:0] alu_a, alu_b, alu_f;
   logic [1:0] alu_op;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_dz;
   logic [7:0] rsp_f;

   int n_pass  = 0;
   int n_total = 0;

   alu_arbiter #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_f(alu_f),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_f(rsp_f), .rsp_id(rsp_id), .rsp_dz(rsp_dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; returns 0 on divide by zero so the controller's substitution is visible.
   always_comb begin
      case (alu_op)
         2'b00:   alu_f = alu_a + alu_b;
         2'b01:   alu_f = alu_a - alu_b;
         2'b10:   alu_f = 8'(alu_a * alu_b);
         default: alu_f = (alu_b == 8'd0) ? 8'd0 : alu_a / alu_b;
      endcase
   end

   function automatic logic [7:0] ref_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return p[7:0];
         default: return (b == 8'd0) ? 8'hFF : a / b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [7:0] exp_f, input logic exp_dz);
      if (id == 1'b0) begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
      end else begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
      end
      #1;
      chk("grant", {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("alu_a", 32'(alu_a), 32'(a));
      chk("alu_b", 32'(alu_b), 32'(b));
      chk("alu_op", 32'(alu_op), 32'(op));
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_f", 32'(rsp_f), 32'(exp_f));
      chk("rsp_id", 32'(rsp_id), 32'(id));
      chk("rsp_dz", 32'(rsp_dz), 32'(exp_dz));
      @(negedge clk);
      chk("rsp_done", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic [7:0] exp_v;
      logic       w;
      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_a = 8'd0; req0_b = 8'd0; req0_op = 2'b00;
      req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0; req1_op = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_f", 32'(rsp_f), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_dz", 32'(rsp_dz), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

      // Single op and truncation/wrap cases
      do_op(1'b0, 8'd20, 8'd7, 2'b00, 8'd27, 1'b0);
      do_op(1'b1, 8'd200, 8'd100, 2'b00, 8'd44, 1'b0);
      do_op(1'b1, 8'd16, 8'd17, 2'b10, 8'h10, 1'b0);
      do_op(1'b1, 8'd5, 8'd9, 2'b01, 8'hFC, 1'b0);
      do_op(1'b0, 8'd9, 8'd0, 2'b11, 8'hFF, 1'b1);
      do_op(1'b0, 8'd100, 8'd7, 2'b11, 8'd14, 1'b0);

      // Back-pressure: response held for 10 cycles while req1 waits
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 8'd12; req0_b = 8'd12; req0_op = 2'b10;
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 8'd7; req1_b = 8'd2; req1_op = 2'b01;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_f", 32'(rsp_f), 32'h90);
         chk("bp_id", 32'(rsp_id), 32'd0);
         chk("bp_dz", 32'(rsp_dz), 32'd0);
         chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 32'(rsp_valid), 32'd0);
      chk("bp_release_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
      @(negedge clk);
      req1_valid = 1'b0;
      chk("bp_next_alu_a", 32'(alu_a), 32'd7);
      chk("bp_next_alu_op", 32'(alu_op), 32'd1);
      @(negedge clk);
      chk("bp_next_f", 32'(rsp_f), 32'd5);
      chk("bp_next_id", 32'(rsp_id), 32'd1);
      @(negedge clk);

      // Simultaneous rst and valid: no accept
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = 8'd77; req0_b = 8'd1; req0_op = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b0;
      @(negedge clk);
      chk("rstvalid_alu_a", 32'(alu_a), 32'd0);
      chk("rstvalid_rsp_valid", 32'(rsp_valid), 32'd0);

      // Fairness: both valid continuously, last=1 after reset so req0 wins first
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         req0_a = 8'(30 + k); req0_b = 8'd3; req0_op = 2'(k);
         req1_a = 8'(50 + k); req1_b = 8'd4; req1_op = ~2'(k);
         w = 1'(k);
         exp_v = w ? ref_f(req1_a, req1_b, req1_op) : ref_f(req0_a, req0_b, req0_op);
         #1;
         chk("fair_grant", {30'd0, req1_ready, req0_ready}, w ? 32'd2 : 32'd1);
         @(negedge clk);
         chk("fair_alu_a", 32'(alu_a), w ? 32'(50 + k) : 32'(30 + k));
         chk("fair_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
         @(negedge clk);
         chk("fair_id", 32'(rsp_id), 32'(w));
         chk("fair_f", 32'(rsp_f), 32'(exp_v));
         chk("fair_resp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Reset during EXEC drops the operation
      req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4; req0_op = 2'b10;
      @(negedge clk);
      req0_valid = 1'b0;
      chk("midop_exec_alu_a", 32'(alu_a), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midop_alu_a", 32'(alu_a), 32'd0);
      chk("midop_alu_b", 32'(alu_b), 32'd0);
      chk("midop_alu_op", 32'(alu_op), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midop_no_rsp", 32'(rsp_valid), 32'd0);
      end
      do_op(1'b1, 8'd60, 8'd6, 2'b11, 8'd10, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
